// File: rtl/alu_pkg.sv
// Shared mini-ALU types: datapath width, arbiter FSM states, operation bundle.
// Imported by the add/sub arbiter, its interface and the six-bit adder.
package alu_pkg;

  localparam int ALU_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } addarb_state_t;

  typedef struct packed {
    logic [ALU_W-1:0] x;
    logic [ALU_W-1:0] y;
    logic             sub;
  } alu_op_t;

endpackage

// File: rtl/alu_addsub_arbiter_if.sv
// Request/response bundle between ALU front-end ports and the add/sub arbiter.
// master = requesters + consumer, slave = arbiter. rsp_ovf needs ADDARB_OVF_EN.
interface alu_addsub_arbiter_if #(
  parameter int N_REQ = 4
);
  import alu_pkg::*;

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [ALU_W*N_REQ-1:0] req_x;
  logic [ALU_W*N_REQ-1:0] req_y;
  logic [N_REQ-1:0]       req_sub;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [ALU_W-1:0]       rsp_s;
`ifdef ADDARB_OVF_EN
  logic                   rsp_ovf;

  modport master (
    output req_valid, req_x, req_y,
    output req_sub, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_id, rsp_s, rsp_ovf
  );

  modport slave (
    input  req_valid, req_x, req_y,
    input  req_sub, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_id, rsp_s, rsp_ovf
  );
`else
  modport master (
    output req_valid, req_x, req_y,
    output req_sub, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_id, rsp_s
  );

  modport slave (
    input  req_valid, req_x, req_y,
    input  req_sub, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_id, rsp_s
  );
`endif

endinterface

// File: rtl/six_bit_adder.sv
// Six-bit add/subtract datapath: s = x + (y ^ {6{sel}}) + sel, mod 2^6.
// Ports: x, y operands; sel 1 = subtract; s result.
module six_bit_adder
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] x,
  input  logic [ALU_W-1:0] y,
  input  logic             sel,
  output logic [ALU_W-1:0] s
);

  assign s = x + (y ^ {ALU_W{sel}})
           + {{(ALU_W-1){1'b0}}, sel};

endmodule

// File: rtl/alu_addsub_arbiter.sv
// Round-robin arbiter sharing one six_bit_adder; tagged registered response.
// Ports: clk, rst_n, bus (slave). ADDARB_OVF_EN adds the rsp_ovf register.
module alu_addsub_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_addsub_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  addarb_state_t   state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] id;
  logic [ID_W-1:0] win;
  logic            found;
  int              idx;
  alu_op_t         op;
  alu_op_t         sel_op;
  logic [ALU_W-1:0] sum;

  // Scan starts just after the last winner and wraps, so every
  // persistent requester is served within N_REQ-1 other grants.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    idx    = 0;
    sel_op = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && bus.req_valid[ID_W'(idx)]) begin
        found      = 1'b1;
        win        = ID_W'(idx);
        sel_op.x   = bus.req_x[idx*ALU_W +: ALU_W];
        sel_op.y   = bus.req_y[idx*ALU_W +: ALU_W];
        sel_op.sub = bus.req_sub[ID_W'(idx)];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found)
      bus.req_ready[win] = 1'b1;
  end

  six_bit_adder u_add (
    .x   (op.x),
    .y   (op.y),
    .sel (op.sub),
    .s   (sum)
  );

`ifdef ADDARB_OVF_EN
  logic ye5;
  logic ovf;

  assign ye5 = op.y[ALU_W-1] ^ op.sub;
  assign ovf = (op.x[ALU_W-1] == ye5)
            && (sum[ALU_W-1] != op.x[ALU_W-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= ID_W'(N_REQ - 1);
      id            <= '0;
      op            <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_s     <= '0;
`ifdef ADDARB_OVF_EN
      bus.rsp_ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            op    <= sel_op;
            id    <= win;
            last  <= win;
            state <= CALC;
          end
        end
        CALC: begin
          bus.rsp_s     <= sum;
          bus.rsp_id    <= id;
          bus.rsp_valid <= 1'b1;
`ifdef ADDARB_OVF_EN
          bus.rsp_ovf   <= ovf;
`endif
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Directed bench for alu_addsub_arbiter with hand-computed results.
// Define ADDARB_OVF_EN to also check rsp_ovf.
module tb_alu_addsub_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_addsub_arbiter_if #(.N_REQ(4)) bus ();

  alu_addsub_arbiter #(.N_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input int r,
                        input logic [5:0] x,
                        input logic [5:0] y,
                        input logic sub);
    bus.req_x[r*6 +: 6] = x;
    bus.req_y[r*6 +: 6] = y;
    bus.req_sub[r]      = sub;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int r,
                         input logic [5:0] x,
                         input logic [5:0] y,
                         input logic sub,
                         input logic [5:0] es,
                         input logic eo);
    set_op(r, x, y, sub);
    bus.req_valid = 4'(1 << r);
    #1;
    check("acc_ready", bus.req_ready, 1 << r);
    tick();
    bus.req_valid = '0;
    check("calc_ready", bus.req_ready, 0);
    check("calc_valid", bus.rsp_valid, 0);
    tick();
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_id", bus.rsp_id, r);
    check("rsp_s", bus.rsp_s, es);
`ifdef ADDARB_OVF_EN
    check("rsp_ovf", bus.rsp_ovf, eo);
`endif
    tick();
    check("rsp_clear", bus.rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) tick();
    check("rst_ready", bus.req_ready, 0);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_s", bus.rsp_s, 0);
`ifdef ADDARB_OVF_EN
    check("rst_ovf", bus.rsp_ovf, 0);
`endif
    rst_n = 1'b1;
    tick();

    run_one(2, 6'd12, 6'd7, 1'b0, 6'd19, 1'b0);
    run_one(1, 6'd5, 6'd9, 1'b1, 6'd60, 1'b0);
    run_one(0, 6'd63, 6'd1, 1'b0, 6'd0, 1'b0);
    run_one(3, 6'd31, 6'd1, 1'b0, 6'd32, 1'b1);
    run_one(3, 6'd0, 6'd1, 1'b1, 6'd63, 1'b0);

    // all four continuously valid from reset
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++)
      set_op(i, 6'(i + 1), 6'd10, 1'b0);
    bus.req_valid = 4'hF;
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("rr_ready", bus.req_ready, 1 << (g % 4));
      tick();
      tick();
      check("rr_id", bus.rsp_id, g % 4);
      check("rr_s", bus.rsp_s, (g % 4) + 11);
      tick();
    end

    // back-pressure, last winner was 0
    bus.rsp_ready = 1'b0;
    check("bp_ready", bus.req_ready, 4'b0010);
    tick();
    tick();
    check("bp_valid0", bus.rsp_valid, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_id", bus.rsp_id, 1);
      check("bp_s", bus.rsp_s, 12);
      check("bp_rdy0", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_rel_rdy", bus.req_ready, 0);
    tick();
    check("bp_done", bus.rsp_valid, 0);
    check("bp_next", bus.req_ready, 4'b0100);
    bus.req_valid = '0;
    #1;
    check("bp_drop", bus.req_ready, 0);

    // last = 1, requesters 1 and 3
    bus.req_valid = 4'b1010;
    #1;
    check("p13_first", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = 4'b0010;
    tick();
    check("p13_id3", bus.rsp_id, 3);
    check("p13_s3", bus.rsp_s, 14);
    tick();
    check("p13_second", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    tick();
    check("p13_id1", bus.rsp_id, 1);
    tick();

    // reset while holding a result
    bus.req_valid = 4'b0100;
    #1;
    check("rh_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    tick();
    check("rh_hold", bus.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rh_valid", bus.rsp_valid, 0);
    check("rh_s", bus.rsp_s, 0);
    check("rh_id", bus.rsp_id, 0);
    check("rh_rdy", bus.req_ready, 0);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 4'b1001;
    #1;
    check("rh_prio", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    check("rh_id0", bus.rsp_id, 0);
    check("rh_s0", bus.rsp_s, 11);
    tick();

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
